// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - md_ctrl op/state encodings and op classification (MD_MADD_EN adds MADD family)
package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } mdOp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdState_e;

  function automatic logic isMulOp(input logic [3:0] op);
`ifdef MD_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isMdBusyOp(input logic [3:0] op);
    return isMulOp(op) || isDivOp(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational HI/LO result generator for md_ctrl (MD_MADD_EN enables accumulate ops)
module md_arith
  import md_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] nextHi,
  output logic [31:0] nextLo,
  output logic        divZero
);

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic signed [31:0] sDivisor;
  logic signed [31:0] sQuot;
  logic signed [31:0] sRem;
  logic        [31:0] uDivisor;
  logic               divOverflow;

  // Divisors are forced to 1 on the corner cases so the dividers never see /0 or overflow.
  assign divOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sDivisor    = (b == 32'd0 || divOverflow) ? 32'sd1 : $signed(b);
  assign uDivisor    = (b == 32'd0) ? 32'd1 : b;
  assign sQuot       = $signed(a) / sDivisor;
  assign sRem        = $signed(a) % sDivisor;
  assign sProd       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uProd       = {32'd0, a} * {32'd0, b};
  assign divZero     = isDivOp(op) && (b == 32'd0);

  always_comb begin
    nextHi = hi;
    nextLo = lo;
    case (op)
      MD_MULT:  {nextHi, nextLo} = sProd;
      MD_MULTU: {nextHi, nextLo} = uProd;
      MD_DIV: begin
        if (divOverflow) begin
          nextHi = 32'd0;
          nextLo = 32'h8000_0000;
        end else if (!divZero) begin
          nextHi = sRem;
          nextLo = sQuot;
        end
      end
      MD_DIVU: begin
        if (!divZero) begin
          nextHi = a % uDivisor;
          nextLo = a / uDivisor;
        end
      end
`ifdef MD_MADD_EN
      MD_MADD:  {nextHi, nextLo} = {hi, lo} + sProd;
      MD_MADDU: {nextHi, nextLo} = {hi, lo} + uProd;
      MD_MSUB:  {nextHi, nextLo} = {hi, lo} - sProd;
      MD_MSUBU: {nextHi, nextLo} = {hi, lo} - uProd;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer owning HI/LO; MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdState_e    state;
  logic [3:0]  cnt;
  logic [3:0]  opLatch;
  logic [31:0] aLatch;
  logic [31:0] bLatch;
  logic [31:0] nextHi;
  logic [31:0] nextLo;
  logic        divZero;

  md_arith uArith (
    .op     (opLatch),
    .a      (aLatch),
    .b      (bLatch),
    .hi     (hi),
    .lo     (lo),
    .nextHi (nextHi),
    .nextLo (nextLo),
    .divZero(divZero)
  );

  // Combinational on start so the dependent D-stage instruction stalls in the issue cycle.
  assign busy = (start && isMdBusyOp(op)) || (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      opLatch <= 4'd0;
      aLatch  <= 32'd0;
      bLatch  <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            if (isMulOp(op)) begin
              state   <= S_MUL;
              cnt     <= 4'(MUL_CYCLES - 1);
              opLatch <= op;
              aLatch  <= src_a;
              bLatch  <= src_b;
            end else if (isDivOp(op)) begin
              state   <= S_DIV;
              cnt     <= 4'(DIV_CYCLES - 1);
              opLatch <= op;
              aLatch  <= src_a;
              bLatch  <= src_b;
            end else if (op == MD_MTHI) begin
              hi <= src_a;
            end else if (op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        default: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= S_IDLE;
            if (!divZero) begin
              hi <= nextHi;
              lo <= nextLo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - scoreboard bench for md_ctrl (honours MD_MADD_EN)
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MUL_LEN = 6;
  localparam int DIV_LEN = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t busyQ[$];
  exp_t quietQ[$];

  int   checks = 0;
  int   failures = 0;
  int   violations = 0;
  logic monOn = 1'b0;
  logic prevBusy;
  int   busyLen;
  logic [31:0] prevHi;
  logic [31:0] prevLo;

  always #5 clk = ~clk;

  md_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .src_a(src_a),
    .src_b(src_b),
    .flush(flush),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expectBusy(input logic [31:0] h, input logic [31:0] l, input int n);
    exp_t e;
    e.hi = h; e.lo = l; e.len = n;
    busyQ.push_back(e);
  endtask

  task automatic expectQuiet(input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.hi = h; e.lo = l; e.len = 0;
    quietQ.push_back(e);
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout busy=%b required=0", busy);
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: a busy fall is a result event; a HI/LO change while idle is a move event.
  initial begin
    exp_t e;
    wait (monOn);
    prevBusy = busy; busyLen = 0; prevHi = hi; prevLo = lo;
    forever begin
      @(negedge clk);
      if (start && busy && prevBusy) violations++;
      if (busy) begin
        busyLen++;
      end else if (prevBusy) begin
        if (busyQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL busy_event unexpected hi=%h lo=%h required=none", hi, lo);
        end else begin
          e = busyQ.pop_front();
          check32("result_hi", hi, e.hi);
          check32("result_lo", lo, e.lo);
          checkInt("busy_len", busyLen, e.len);
        end
        busyLen = 0;
      end else if (hi !== prevHi || lo !== prevLo) begin
        if (quietQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL hilo_change unexpected hi=%h lo=%h required=%h/%h", hi, lo, prevHi, prevLo);
        end else begin
          e = quietQ.pop_front();
          check32("move_hi", hi, e.hi);
          check32("move_lo", lo, e.lo);
        end
      end
      prevBusy = busy; prevHi = hi; prevLo = lo;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = MD_NONE; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    checkInt("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    monOn = 1'b1;
    @(posedge clk);

    expectBusy(32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LEN);
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    waitIdle();

    expectBusy(32'd2, 32'd14, DIV_LEN);
    issue(MD_DIVU, 32'd100, 32'd7);
    waitIdle();

    expectBusy(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LEN);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle();

    expectQuiet(32'hFFFF_FFFF, 32'h0000_1234);
    issue(MD_MTLO, 32'h0000_1234, 32'd0);
    waitIdle();

    expectBusy(32'hFFFF_FFFF, 32'h0000_1234, DIV_LEN);
    issue(MD_DIV, 32'd5, 32'd0);
    waitIdle();

    expectBusy(32'd0, 32'h8000_0000, DIV_LEN);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();

    expectBusy(32'hFFFF_FFFE, 32'h0000_0001, MUL_LEN);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle();

    // Flush in the third busy cycle: no commit, busy lasts 3 cycles.
    expectBusy(32'hFFFF_FFFE, 32'h0000_0001, 3);
    issue(MD_MULT, 32'd9, 32'd9);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    waitIdle();

    expectQuiet(32'h0000_ABCD, 32'h0000_0001);
    issue(MD_MTHI, 32'h0000_ABCD, 32'd0);
    waitIdle();

    // flush together with start: the move must be dropped.
    @(posedge clk); #1;
    flush = 1'b1; start = 1'b1; op = MD_MTHI; src_a = 32'h5555_5555;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; op = MD_NONE;
    issue(MD_NONE, 32'h1111_1111, 32'd2);
    issue(4'd15, 32'h2222_2222, 32'd3);
    waitIdle();

    // A stray start during MUL must be ignored and flagged as a violation.
    expectBusy(32'd0, 32'd42, MUL_LEN);
    issue(MD_MULT, 32'd7, 32'd6);
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NONE;
    waitIdle();

    expectBusy(32'd1, 32'hFFFF_FFFD, DIV_LEN);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    waitIdle();

    expectQuiet(32'd0, 32'hFFFF_FFFD);
    issue(MD_MTHI, 32'd0, 32'd0);
    waitIdle();
    expectQuiet(32'd0, 32'd10);
    issue(MD_MTLO, 32'd10, 32'd0);
    waitIdle();

`ifdef MD_MADD_EN
    expectBusy(32'd0, 32'd22, MUL_LEN);
`endif
    issue(MD_MADD, 32'd3, 32'd4);
    waitIdle();
    repeat (3) @(posedge clk);
    #1;

`ifdef MD_MADD_EN
    check32("final_lo", lo, 32'd22);
`else
    check32("final_lo", lo, 32'd10);
`endif
    check32("final_hi", hi, 32'd0);
    checkInt("start_while_busy", violations, 1);
    checkInt("busy_queue_left", busyQ.size(), 0);
    checkInt("quiet_queue_left", quietQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequences the pipeline's shared multiply/divide resource and owns the HI/LO registers.
- Accepts one operation per issue from the E stage and models the multi-cycle latency with a down-counter.
- Drives the `busy` signal the hazard unit combines with the D-stage md tag to stall.
- Sits beside the ALU in E; HI/LO feed MFHI/MFLO through the E-stage result mux.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  E-stage issue strobe, qualified by a valid md op.
- op  input  4  operation code, encodings from md_defs.
- src_a  input  32  forwarded rs value.
- src_b  input  32  forwarded rt value.
- flush  input  1  pipeline flush (exception/eret); aborts the in-flight op.
- busy  output  1  resource occupied; feeds the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, busy=0, hi=0, lo=0, operand latches=0.
  - Reset asserted mid-operation discards the op immediately; HI/LO return to 0.
- States and transitions:
  - IDLE: start with MULT/MULTU/MADD* goes to MUL with cnt=MUL_CYCLES-1.
  - IDLE: start with DIV/DIVU goes to DIV with cnt=DIV_CYCLES-1.
  - IDLE: start with MTHI/MTLO writes hi/lo=src_a at the same edge and stays in IDLE.
  - MUL/DIV: cnt decrements each cycle. When cnt==0 at a clock edge, commit the result to hi/lo and return to IDLE.
- Operand capture:
  - src_a, src_b and op are latched at the start edge.
  - Results are computed from the latched copies only.
  - Later changes on src_a/src_b/op are ignored.
- busy:
  - busy = (start & op is MULT/MULTU/DIV/DIVU/MADD*) | (state!=IDLE).
  - It is combinational on start, so the D-stage instruction behind the issuing one stalls in the same cycle.
  - busy is high for exactly N+1 cycles per op (issue cycle plus N state cycles).
  - New HI/LO values are visible in the first cycle busy=0.
- MTHI/MTLO never raise busy.
- Arithmetic:
  - MULT: {hi,lo}=signed 32x32 to 64.
  - MULTU: {hi,lo}=unsigned 32x32 to 64.
  - DIV: lo=signed quotient, hi=signed remainder, truncated toward zero; the remainder takes the sign of the dividend.
  - DIVU: same as DIV, unsigned.
- Division by zero:
  - Completes with normal timing; hi/lo are left unchanged.
  - Signed 0x80000000/-1 gives lo=0x80000000, hi=0.
- start while state!=IDLE is ignored; the hazard unit guarantees this cannot happen and the bench asserts on it.
- flush:
  - In MUL/DIV: go to IDLE next edge, no commit, busy=0 next cycle.
  - flush && start in the same cycle: start is ignored, including MTHI/MTLO.
- op=MD_NONE or an unknown code with start: no effect.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: MADD, MADDU, MSUB, MSUBU are accepted with MUL_CYCLES latency. At commit, {hi,lo} = {hi,lo} ± product (signed or unsigned), using the HI/LO values present at commit.
- Undefined: those codes are treated as unknown (no effect, busy stays 0).

Decomposition:
- Shared header md_defs.v holds:
  - the op encodings: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - the state encodings IDLE/MUL/DIV;
  - the is_md_busy_op classification define.
- One sub-module, md_arith: purely combinational. It takes latched op/a/b and current hi/lo and returns next {hi,lo} plus a div_by_zero flag.
- md_ctrl holds the FSM, counter, latches and registers.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE(-2), b=3 -> busy high 6 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=100, b=7 -> busy 11 cycles; then lo=14, hi=2. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 after MTLO 0x1234 -> hi/lo unchanged (lo=0x1234), busy drops on schedule.
- MULT issued; flush at cycle 3 of busy -> busy=0 next cycle, hi/lo keep their pre-MULT values.
- MTHI 0xABCD with start -> hi=0xABCD the next cycle, busy never asserts; a start pulse during MUL -> ignored and the assertion fires.
- With MD_MADD_EN: MTHI 0, MTLO 10, MADD a=3, b=4 -> lo=22, hi=0. Without the macro, the same op code leaves lo=10 and busy stays 0.
